// File: rtl/input_conditioner.sv
// Two-flop synchroniser plus per-channel debounce for the push-button and DIP switches.
// Forwards only stable levels and emits single-cycle press/release/change pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       key_n_raw,
  input  logic [3:0] dipsw_raw,
  output logic       button_pio_export,
  output logic [3:0] dipsw_pio_export,
  output logic       button_press,
  output logic       button_release,
  output logic [3:0] dipsw_change
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ch0 is the button, inverted so that 1 = pressed and a released key resets to 0
  logic [NCH-1:0] w_raw;
  assign w_raw = {dipsw_raw, ~key_n_raw};

  logic [NCH-1:0]   r_sync1_p0;
  logic [NCH-1:0]   r_sync2_p1;
  logic [NCH-1:0]   r_stable_p2;
  logic [NCH-1:0]   r_pulse_p2;
  logic [CNT_W-1:0] r_cnt_p2 [NCH];

  logic [NCH-1:0]   w_stable_nxt;
  logic [NCH-1:0]   w_pulse_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [NCH];

  function automatic logic cnt_done(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_LAST;
  endfunction

  // p0/p1: two-flop synchroniser
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1_p0 <= '0;
      r_sync2_p1 <= '0;
    end else begin
      r_sync1_p0 <= w_raw;
      r_sync2_p1 <= r_sync1_p0;
    end
  end

  // p2: debounce; a mismatch must persist DEBOUNCE_CYCLES edges before acceptance
  always_comb begin
    w_stable_nxt = r_stable_p2;
    w_pulse_nxt  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      w_cnt_nxt[ch] = '0;
      if (r_sync2_p1[ch] != r_stable_p2[ch]) begin
        if (cnt_done(r_cnt_p2[ch])) begin
          w_stable_nxt[ch] = r_sync2_p1[ch];
          w_pulse_nxt[ch]  = 1'b1;
        end else begin
          w_cnt_nxt[ch] = r_cnt_p2[ch] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_stable_p2 <= '0;
      r_pulse_p2  <= '0;
      for (int ch = 0; ch < NCH; ch++) r_cnt_p2[ch] <= '0;
    end else begin
      r_stable_p2 <= w_stable_nxt;
      r_pulse_p2  <= w_pulse_nxt;
      for (int ch = 0; ch < NCH; ch++) r_cnt_p2[ch] <= w_cnt_nxt[ch];
    end
  end

  assign button_pio_export = r_stable_p2[0];
  assign dipsw_pio_export  = r_stable_p2[4:1];
  assign button_press      = r_pulse_p2[0] & r_stable_p2[0];
  assign button_release    = r_pulse_p2[0] & ~r_stable_p2[0];
  assign dipsw_change      = r_pulse_p2[4:1];

endmodule
